// File: rtl/hermes_switch_ctrl.sv
// Switch-allocation controller for one Hermes mesh router: XY routing, round-robin
// arbitration among header requests, and crossbar select tables held until packet end.
`timescale 1ns/1ps
module hermes_switch_ctrl #(
   parameter int         FLIT_WIDTH = 32,
   parameter int         NPORT      = 5,
   parameter logic [7:0] ADDR_X     = 8'd0,
   parameter logic [7:0] ADDR_Y     = 8'd0
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [NPORT-1:0]            req_i,
   input  logic [NPORT*FLIT_WIDTH-1:0] hdr_i,
   input  logic [NPORT-1:0]            sender_i,
   output logic [NPORT-1:0]            ack_h_o,
   output logic [NPORT-1:0]            free_o,
   output logic [NPORT*3-1:0]          mux_in_o,
   output logic [NPORT*3-1:0]          mux_out_o
);

   typedef enum logic [1:0] {IDLE, ARB, ROUTE, GRANT} state_t;

   state_t           state, state_nxt;
   logic [NPORT-1:0] conn;
   logic [2:0]       prio;
   logic [2:0]       sel;
   logic [2:0]       dest;
   logic [NPORT-1:0] elig;
   logic [3:0]       pick;
   logic [2:0]       route_dest;
   logic [15:0]      addr_a [NPORT];
   logic             unused_hdr;

   // Round-robin scan starting just after the last served input; returns {found, index}.
   function automatic logic [3:0] rr_pick(input logic [NPORT-1:0] req, input logic [2:0] last);
      logic [3:0] res;
      logic [2:0] idx;
      res = '0;
      for (int i = 1; i <= NPORT; i++) begin
         idx = 3'((int'(last) + i) % NPORT);
         if (!res[3] && req[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

   function automatic logic [2:0] xy_route(input logic [15:0] addr);
      logic [7:0] tx, ty;
      tx = addr[15:8];
      ty = addr[7:0];
      if (tx > ADDR_X)      return 3'd0;
      else if (tx < ADDR_X) return 3'd1;
      else if (ty > ADDR_Y) return 3'd2;
      else if (ty < ADDR_Y) return 3'd3;
      else                  return 3'd4;
   endfunction

   for (genvar p = 0; p < NPORT; p++) begin : g_addr
      assign addr_a[p] = hdr_i[p*FLIT_WIDTH +: 16];
   end

   // Only the 16-bit target address of each header takes part in routing.
   assign unused_hdr = ^hdr_i;

   assign elig       = req_i & ~conn;
   assign pick       = rr_pick(elig, prio);
   assign route_dest = xy_route(addr_a[sel]);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (|elig) state_nxt = ARB;
         ARB:     state_nxt = pick[3] ? ROUTE : IDLE;
         ROUTE:   state_nxt = free_o[route_dest] ? GRANT : IDLE;
         GRANT:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         conn      <= '0;
         prio      <= 3'(NPORT-1);
         ack_h_o   <= '0;
         free_o    <= '1;
         mux_in_o  <= '0;
         mux_out_o <= '0;
      end else begin
         state   <= state_nxt;
         ack_h_o <= '0;
         // A blocked header hands priority on so the others are served before it retries.
         if (state == ROUTE && !free_o[route_dest]) prio <= sel;
         for (int p = 0; p < NPORT; p++) begin
            if (conn[p] && !sender_i[p]) begin
               conn[p]                          <= 1'b0;
               free_o[mux_out_o[p*3 +: 3]]      <= 1'b1;
            end
         end
         // A grant never targets an output being released, so both updates coexist.
         if (state == GRANT) begin
            ack_h_o[sel]            <= 1'b1;
            free_o[dest]            <= 1'b0;
            mux_out_o[sel*3 +: 3]   <= dest;
            mux_in_o[dest*3 +: 3]   <= sel;
            conn[sel]               <= 1'b1;
            prio                    <= sel;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (state == ARB && pick[3]) sel <= pick[2:0];
      if (state == ROUTE) dest <= route_dest;
   end

endmodule

// File: tb/tb_hermes_switch_ctrl.sv
// Scoreboard bench for hermes_switch_ctrl at router (1,1): directed scenarios plus
// randomized request rounds predicted by an attempt-level allocation model.
`timescale 1ns/1ps
module tb_hermes_switch_ctrl;
   localparam int FW = 32;
   localparam int NP = 5;

   logic               clock = 1'b0;
   logic               reset = 1'b0;
   logic [NP-1:0]      req_i = '0;
   logic [NP*FW-1:0]   hdr_i = '0;
   logic [NP-1:0]      sender_i = '0;
   logic [NP-1:0]      ack_h_o;
   logic [NP-1:0]      free_o;
   logic [NP*3-1:0]    mux_in_o;
   logic [NP*3-1:0]    mux_out_o;

   typedef struct {int src; int dst;} exp_t;
   exp_t sbq[$];
   exp_t mon_e;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int ack_t[NP] = '{default: 0};
   int ack_cnt[NP] = '{default: 0};
   int m_prio = 4;

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   hermes_switch_ctrl #(.FLIT_WIDTH(FW), .NPORT(NP), .ADDR_X(8'd1), .ADDR_Y(8'd1)) dut (
      .clock(clock), .reset(reset), .req_i(req_i), .hdr_i(hdr_i), .sender_i(sender_i),
      .ack_h_o(ack_h_o), .free_o(free_o), .mux_in_o(mux_in_o), .mux_out_o(mux_out_o));

   task automatic chk(input string name, input int act, input int exp_v);
      n_cmp++;
      if (act !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp_v, exp_v, cyc);
      end
   endtask

   // Monitor: every header acceptance pops the next expected grant.
   always @(negedge clock) begin
      if (!reset && ack_h_o != '0) begin
         if (sbq.size() == 0) begin
            chk("unexpected_ack", int'(ack_h_o), 0);
         end else begin
            mon_e = sbq.pop_front();
            chk("ack_onehot", int'(ack_h_o), 1 << mon_e.src);
            chk("mux_out", int'(mux_out_o[mon_e.src*3 +: 3]), mon_e.dst);
            chk("mux_in", int'(mux_in_o[mon_e.dst*3 +: 3]), mon_e.src);
            chk("free_dest_clear", int'(free_o[mon_e.dst]), 0);
            ack_t[mon_e.src]   = cyc;
            ack_cnt[mon_e.src] = ack_cnt[mon_e.src] + 1;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   // One clock; the input buffer drops its header once it has been accepted.
   task automatic tick();
      @(posedge clock);
      #1;
      for (int p = 0; p < NP; p++) if (ack_h_o[p]) req_i[p] = 1'b0;
   endtask

   task automatic set_hdr(input int p, input logic [31:0] v);
      hdr_i[p*FW +: FW] = v;
   endtask

   task automatic expect_ack(input int s, input int d);
      exp_t e;
      e.src = s;
      e.dst = d;
      sbq.push_back(e);
   endtask

   task automatic drain(input int budget, input string name);
      int n = 0;
      while (sbq.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      chk({name, "_pending"}, sbq.size(), 0);
      sbq.delete();
   endtask

   // Reset raised between clock edges must act at once.
   task automatic do_reset(input string name);
      #2;
      reset = 1'b1;
      #1;
      chk({name, "_free"}, int'(free_o), 31);
      chk({name, "_ack"}, int'(ack_h_o), 0);
      chk({name, "_mux_in"}, int'(mux_in_o), 0);
      chk({name, "_mux_out"}, int'(mux_out_o), 0);
      sbq.delete();
      tick();
      reset = 1'b0;
      m_prio = 4;
   endtask

   function automatic int ref_route(input logic [15:0] a);
      int tx, ty;
      tx = int'(a[15:8]);
      ty = int'(a[7:0]);
      if (tx > 1) return 0;
      if (tx < 1) return 1;
      if (ty > 1) return 2;
      if (ty < 1) return 3;
      return 4;
   endfunction

   function automatic logic [7:0] pick_coord();
      case ($urandom_range(0, 4))
         0:       return 8'd0;
         1:       return 8'd1;
         2:       return 8'd2;
         3:       return 8'hFF;
         default: return 8'($urandom_range(0, 255));
      endcase
   endfunction

   // All requests arrive together and nothing is released until the round ends, so the
   // grant order follows purely from the round-robin / blocked-retry rules.
   task automatic random_round(input int r);
      int          s = $urandom_range(1, 31);
      logic [4:0]  sb;
      logic [31:0] hv;
      int          d[NP];
      bit          pend[NP];
      int          free_m = 31;
      int          prio_l;
      int          sel;
      int          guard = 0;
      bit          any_ok;
      bit          blocked = 0;
      logic [4:0]  held;
      logic [4:0]  drop;
      sb = 5'(s);
      prio_l = m_prio;
      for (int p = 0; p < NP; p++) begin
         pend[p] = sb[p];
         d[p] = 0;
         if (sb[p]) begin
            hv = $urandom();
            hv[15:8] = pick_coord();
            hv[7:0]  = pick_coord();
            set_hdr(p, hv);
            d[p] = ref_route(hv[15:0]);
         end
      end
      while (guard < 200) begin
         any_ok = 0;
         for (int p = 0; p < NP; p++) if (pend[p] && ((free_m >> d[p]) & 1) == 1) any_ok = 1;
         if (!any_ok) break;
         sel = -1;
         for (int i = 1; i <= NP; i++) if (sel < 0 && pend[(prio_l + i) % NP]) sel = (prio_l + i) % NP;
         if (((free_m >> d[sel]) & 1) == 1) begin
            expect_ack(sel, d[sel]);
            free_m = free_m & ~(1 << d[sel]);
            pend[sel] = 0;
         end
         prio_l = sel;
         guard++;
      end
      for (int p = 0; p < NP; p++) if (pend[p]) blocked = 1;
      req_i = sb;
      sender_i = sb;
      drain(400, $sformatf("rnd%0d", r));
      repeat (8) tick();
      chk($sformatf("rnd%0d_free", r), int'(free_o), free_m);
      if (blocked) begin
         req_i = '0;
         do_reset($sformatf("rnd%0d_rst", r));
      end else begin
         m_prio = prio_l;
         held = sb;
         while (held != 0) begin
            drop = held & 5'($urandom_range(0, 31));
            if (drop == 0) drop = held;
            sender_i = sender_i & ~drop;
            tick();
            for (int p = 0; p < NP; p++) if (drop[p]) free_m = free_m | (1 << d[p]);
            held = held & ~drop;
            chk($sformatf("rnd%0d_release", r), int'(free_o), free_m);
         end
      end
      sender_i = '0;
   endtask

   initial begin
      int t0;
      int lat;
      int n;

      do_reset("t1_rst");
      tick();

      // LOCAL header to (3,1) leaves EAST
      set_hdr(4, 32'h0000_0301);
      req_i[4] = 1'b1;
      sender_i[4] = 1'b1;
      t0 = cyc;
      expect_ack(4, 0);
      drain(20, "t2");
      chk("t2_latency", ack_t[4] - t0, 4);
      chk("t2_free", int'(free_o), 5'b11110);

      sender_i[4] = 1'b0;
      tick();
      chk("t3_free_released", int'(free_o), 31);
      set_hdr(4, 32'hABCD_0101);
      req_i[4] = 1'b1;
      sender_i[4] = 1'b1;
      t0 = cyc;
      expect_ack(4, 4);
      drain(20, "t3");
      chk("t3_latency", ack_t[4] - t0, 4);
      sender_i[4] = 1'b0;
      tick();
      chk("t3_free_end", int'(free_o), 31);

      // WEST and SOUTH contend for LOCAL
      set_hdr(1, 32'h0000_0101);
      set_hdr(3, 32'h0000_0101);
      req_i[1] = 1'b1;
      req_i[3] = 1'b1;
      sender_i[1] = 1'b1;
      sender_i[3] = 1'b1;
      expect_ack(1, 4);
      drain(30, "t4_west");
      repeat (24) tick();
      chk("t4_south_held", ack_cnt[3], 0);
      chk("t4_free_held", int'(free_o), 5'b01111);
      expect_ack(3, 4);
      sender_i[1] = 1'b0;
      t0 = cyc;
      drain(20, "t4_south");
      lat = ack_t[3] - t0;
      chk("t4_south_lat_le8", int'(lat >= 1 && lat <= 8), 1);
      sender_i[3] = 1'b0;
      tick();
      chk("t4_free_end", int'(free_o), 31);

      // Every input to a distinct output
      do_reset("t5_rst");
      set_hdr(0, 32'h0000_0201);
      set_hdr(1, 32'h0000_0001);
      set_hdr(2, 32'h0000_0102);
      set_hdr(3, 32'h0000_0100);
      set_hdr(4, 32'h0000_0101);
      req_i = '1;
      sender_i = '1;
      for (int p = 0; p < NP; p++) expect_ack(p, p);
      drain(60, "t5");
      for (int i = 0; i < 4; i++) chk($sformatf("t5_spacing%0d", i), ack_t[i+1] - ack_t[i], 4);
      chk("t5_free", int'(free_o), 0);

      // Reset while the third grant is in flight, with two connections open
      sender_i = '0;
      tick();
      chk("t6_free_pre", int'(free_o), 31);
      req_i = '1;
      sender_i = '1;
      for (int p = 0; p < NP; p++) expect_ack(p, p);
      n = 0;
      while (!ack_h_o[1] && n < 40) begin
         tick();
         n++;
      end
      chk("t6_second_ack_seen", int'(ack_h_o[1]), 1);
      chk("t6_free_two_open", int'(free_o), 5'b11100);
      repeat (3) tick();
      do_reset("t6_rst");
      req_i = '1;
      sender_i = '1;
      for (int p = 0; p < NP; p++) expect_ack(p, p);
      drain(60, "t6_after");
      chk("t6_free_end", int'(free_o), 0);
      sender_i = '0;
      tick();
      do_reset("rnd_start");

      for (int r = 0; r < 40; r++) random_round(r);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
